perceptron_stream: RTL
======================

Name: perceptron_stream

Overview:
- Parametrised successor to the fixed-N single-vector perceptron.
- Accepts weight/input vectors as a stream of LANES-wide beats and accumulates dot products across beats, so vector length is bounded only by MAX_BEATS*LANES.
- Adds a bias, applies a run-time selectable activation and saturates the result to DATA_WIDTH.
- Results leave through a valid/ready handshake with full backpressure; this is the neuron primitive for the layer engine.

Parameters:
DATA_WIDTH, 8, signed element width of x, w, b, y
LANES, 4, elements consumed per beat
MAX_BEATS, 16, maximum beats per vector before forced termination
FRAC_BITS, 0, fixed-point fraction bits of x and w; the product is rescaled by arithmetic shift right FRAC_BITS
ACC_WIDTH, 2*DATA_WIDTH+$clog2(LANES*MAX_BEATS)+1, internal accumulator width; never overflows

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid&&in_ready
in_x  input  LANES*DATA_WIDTH  packed signed inputs, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
in_w  input  LANES*DATA_WIDTH  packed signed weights, same packing
in_last  input  1  final beat of the vector
in_b  input  DATA_WIDTH  signed bias, sampled on the last beat
act_mode  input  2  0 identity, 1 ReLU, 2 step, 3 leaky ReLU; sampled on the last beat
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid&&out_ready
out_y  output  DATA_WIDTH  signed result
err_len  output  1  sticky; vector exceeded MAX_BEATS

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: out_valid=0, out_y=0, err_len=0. The accumulator, beat counter and all stage valids clear. in_ready=0 while rst_n=0.
- Reset mid-vector discards all partial state. No result is emitted for the discarded vector.
- Global stall: stall = out_valid && !out_ready. in_ready = rst_n && !stall.
- While stalled, every pipeline register holds and out_y stays stable.
- Stage 1 (acceptance edge): register the LANES signed products, plus the last flag, in_b and act_mode.
- Stage 2: sum the products (adder tree) and add the result into the accumulator.
  - On a last beat, form final = acc + sum + (sign-extended b << FRAC_BITS), then clear the accumulator for the next vector.
  - Back-to-back vectors need no gap cycles.
- Stage 3 (output register):
  - Compute r = final >>> FRAC_BITS.
  - Apply activation:
    - identity: r
    - ReLU: max(r,0)
    - step: 1 if r>0 else 0
    - leaky ReLU: r>=0 ? r : r>>>3, arithmetic shift
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then load out_y and set out_valid.
- Latency: the vector's result appears 3 clock edges after its last beat is accepted. Count the acceptance edge as edge 1. out_valid is high after edge 3 when no stall occurs.
- out_valid drops on the edge where out_ready=1, unless a new result loads on that same edge.
- Beat counter: counts accepted beats of the current vector and resets on the last beat.
  - If MAX_BEATS beats are accepted without in_last, the MAX_BEATS-th beat is treated as last, using in_b and act_mode from that beat, and err_len sets.
  - err_len clears only on reset.
- Simultaneous events:
  - A result drain and a new result load on the same edge: the new result wins and out_valid stays 1.
  - A beat presented with in_valid=1 during a stall is not accepted; the source must hold it stable.
- Non-beat inputs are ignored when in_valid=0.

Test Plan:
All scenarios use DATA_WIDTH=8, LANES=4, FRAC_BITS=0, MAX_BEATS=4 and out_ready=1 unless stated.
1. Single beat: x={1,2,3,4}, w={1,1,1,1}, b=5, mode 0, last -> out_y=15, out_valid high exactly 3 edges after acceptance.
2. Saturation and activation:
   - x=127 all lanes, w=127, b=0, mode 0 -> 127.
   - x=127, w=-128, mode 0 -> -128.
   - Same vector in mode 1 -> 0; mode 3 -> -128, since -65024>>>3 saturates.
   - x={1,0,0,0}, w={-9,0,0,0}, mode 3 -> -2.
3. Multi-beat, back-to-back:
   - Vector A: 3 beats of x={1,1,1,1}, w={2,2,2,2}, b=-4, last on beat 3 -> 20.
   - Vector B: single beat issued the next cycle, x={1,1,1,1}, w={1,1,1,1}, b=0, mode 2 -> 1 the following cycle.
4. Backpressure: hold out_ready=0 while result 20 is valid -> in_ready=0, out_y holds 20 for 5 cycles, the next beat is held unaccepted. Raise out_ready -> 20 drains and the next result follows in order, none lost or duplicated.
5. Length error: 4 beats of x={1,1,1,1}, w={1,1,1,1}, b=0, in_last=0 -> result 16 emitted, err_len=1 and stays 1 through later vectors until reset.
6. Reset mid-vector: accept 2 beats of x=w={3,3,3,3}, pulse rst_n low for one edge, then send a single beat x={1,1,1,1}, w={1,1,1,1}, b=0, last -> out_valid=0 during reset, result 4 (no stale 72), err_len=0.

Source files
------------

// File: rtl/perceptron_stream.sv
// Streaming perceptron neuron: accumulates LANES-wide dot-product beats, adds a bias,
// applies a selectable activation and saturates the result behind a valid/ready handshake.
module perceptron_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int MAX_BEATS  = 16,
  parameter int FRAC_BITS  = 0,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(LANES*MAX_BEATS) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_x,
  input  logic [LANES*DATA_WIDTH-1:0]   in_w,
  input  logic                          in_last,
  input  logic signed [DATA_WIDTH-1:0]  in_b,
  input  logic [1:0]                    act_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_y,
  output logic                          err_len
);

  localparam int PROD_WIDTH  = 2*DATA_WIDTH;
  localparam int TREE_LEAVES = 1 << $clog2(LANES);
  localparam int CNT_WIDTH   = $clog2(MAX_BEATS + 1);

  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic signed [ACC_WIDTH-1:0] activate(
    input logic signed [ACC_WIDTH-1:0] r,
    input logic [1:0]                  mode
  );
    logic signed [ACC_WIDTH-1:0] a;
    a = r;
    case (mode)
      2'd0:    a = r;
      2'd1:    a = r[ACC_WIDTH-1] ? '0 : r;
      2'd2:    a = (!r[ACC_WIDTH-1] && (r != '0)) ? ACC_ONE : '0;
      2'd3:    a = r[ACC_WIDTH-1] ? (r >>> 3) : r;
      default: a = r;
    endcase
    return a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] y;
    if (v > Y_MAX) begin
      y = Y_MAX[DATA_WIDTH-1:0];
    end else if (v < Y_MIN) begin
      y = Y_MIN[DATA_WIDTH-1:0];
    end else begin
      y = v[DATA_WIDTH-1:0];
    end
    return y;
  endfunction

  logic                         stall_s;
  logic                         accept_s;
  logic                         force_last_s;
  logic                         last_s;
  logic [CNT_WIDTH-1:0]         beat_cnt_r;

  logic signed [PROD_WIDTH-1:0] prod_s [LANES];
  logic signed [PROD_WIDTH-1:0] prod_r [LANES];
  logic                         s1_valid_r;
  logic                         s1_last_r;
  logic signed [DATA_WIDTH-1:0] s1_b_r;
  logic [1:0]                   s1_mode_r;

  logic signed [ACC_WIDTH-1:0]  tree_s [1:2*TREE_LEAVES-1];
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [ACC_WIDTH-1:0]  bias_s;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic signed [ACC_WIDTH-1:0]  final_r;
  logic                         s2_valid_r;
  logic [1:0]                   s2_mode_r;

  logic signed [ACC_WIDTH-1:0]  r_s;
  logic [DATA_WIDTH-1:0]        y_s;

  // A held result freezes the whole pipeline, so nothing upstream can be overwritten.
  assign stall_s      = out_valid && !out_ready;
  assign in_ready     = rst_n && !stall_s;
  assign accept_s     = in_valid && in_ready;
  assign force_last_s = (beat_cnt_r == CNT_WIDTH'(MAX_BEATS - 1)) && !in_last;
  assign last_s       = in_last || force_last_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] x_s;
    logic signed [DATA_WIDTH-1:0] w_s;
    assign x_s       = in_x[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_s       = in_w[i*DATA_WIDTH +: DATA_WIDTH];
    assign prod_s[i] = PROD_WIDTH'(x_s) * PROD_WIDTH'(w_s);
  end

  // Heap-indexed adder tree: node n sums nodes 2n and 2n+1, unused leaves are zero.
  for (genvar i = 0; i < TREE_LEAVES; i++) begin : g_leaf
    if (i < LANES) begin : g_used
      assign tree_s[TREE_LEAVES+i] = ACC_WIDTH'(prod_r[i]);
    end else begin : g_pad
      assign tree_s[TREE_LEAVES+i] = '0;
    end
  end

  for (genvar n = 1; n < TREE_LEAVES; n++) begin : g_node
    assign tree_s[n] = tree_s[2*n] + tree_s[2*n+1];
  end

  assign sum_s  = tree_s[1];
  assign bias_s = ACC_WIDTH'(s1_b_r) <<< FRAC_BITS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_r <= '0;
      err_len    <= 1'b0;
    end else if (accept_s) begin
      beat_cnt_r <= last_s ? '0 : beat_cnt_r + CNT_WIDTH'(1);
      if (force_last_s) begin
        err_len <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_r     <= '{default: '0};
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_b_r     <= '0;
      s1_mode_r  <= 2'b00;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        prod_r    <= prod_s;
        s1_last_r <= last_s;
        s1_b_r    <= in_b;
        s1_mode_r <= act_mode;
      end
    end
  end

  // The accumulator restarts from zero right after a last beat, so vectors can run back-to-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r      <= '0;
      final_r    <= '0;
      s2_valid_r <= 1'b0;
      s2_mode_r  <= 2'b00;
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r && s1_last_r;
      if (s1_valid_r) begin
        if (s1_last_r) begin
          final_r   <= acc_r + sum_s + bias_s;
          acc_r     <= '0;
          s2_mode_r <= s1_mode_r;
        end else begin
          acc_r <= acc_r + sum_s;
        end
      end
    end
  end

  always_comb begin
    r_s = final_r >>> FRAC_BITS;
    y_s = saturate(activate(r_s, s2_mode_r));
  end

  // When not stalled the output register is either empty or draining, so it can always reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (!stall_s) begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        out_y <= y_s;
      end
    end
  end

endmodule
